// File: rtl/dm_port_arbiter.sv
// Two-port arbiter for the single-port data memory: CPU (port 0) has fixed
// priority, the DMA (port 1) is guaranteed a slot by a starvation counter.
module dm_port_arbiter #(
  parameter int unsigned STARVE_LIM = 4,
  parameter int unsigned AW         = 12
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [31:0]   p0_wdata,
  input  logic [1:0]    p0_mode,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  output logic          p0_err,

  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [31:0]   p1_wdata,
  input  logic [1:0]    p1_mode,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic          p1_err,

  output logic [31:0]   rdata,

  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_din,
  output logic          mem_we,
  output logic [1:0]    mem_mode,
  input  logic [31:0]   mem_dout
);

  localparam logic [3:0] LIM        = 4'(STARVE_LIM);
  localparam logic [1:0] MODE_WORD  = 2'b00;
  localparam logic [1:0] MODE_ILLEG = 2'b11;

  logic [3:0] starve_q, starve_d;
  logic       rv_valid_q, rv_valid_d;
  logic       rv_sel_q, rv_sel_d;
  logic       rv_err_q, rv_err_d;

  logic       p1_wins;
  logic       granted;
  logic       win_we;
  logic [1:0] win_mode;
  logic       win_illegal;

  always_comb begin
    p1_wins     = p1_req && (!p0_req || (starve_q == LIM));
    granted     = !rst && (p0_req || p1_req);

    // With no request the mux stays on port 0, so its fields appear on the bus.
    mem_addr    = p1_wins ? p1_addr  : p0_addr;
    mem_din     = p1_wins ? p1_wdata : p0_wdata;
    win_we      = p1_wins ? p1_we    : p0_we;
    win_mode    = p1_wins ? p1_mode  : p0_mode;
    win_illegal = (win_mode == MODE_ILLEG);

    p0_gnt      = granted && !p1_wins;
    p1_gnt      = granted && p1_wins;

    // Mode 11 with WE=0 would clear the word, so an illegal access never reaches memory.
    mem_we      = granted && win_we && !win_illegal;
    mem_mode    = (granted && !win_illegal) ? win_mode : MODE_WORD;
  end

  always_comb begin
    starve_d = starve_q;
    if (!p1_req || p1_gnt) begin
      starve_d = 4'd0;
    end else if (starve_q < LIM) begin
      starve_d = starve_q + 4'd1;
    end
    rv_valid_d = granted;
    rv_sel_d   = p1_gnt;
    rv_err_d   = granted && win_illegal;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q   <= 4'd0;
      rv_valid_q <= 1'b0;
      rv_sel_q   <= 1'b0;
      rv_err_q   <= 1'b0;
    end else begin
      starve_q   <= starve_d;
      rv_valid_q <= rv_valid_d;
      rv_sel_q   <= rv_sel_d;
      rv_err_q   <= rv_err_d;
    end
  end

  // Reset in the response cycle suppresses the response immediately.
  always_comb begin
    p0_rvalid = !rst && rv_valid_q && !rv_sel_q;
    p1_rvalid = !rst && rv_valid_q && rv_sel_q;
    p0_err    = p0_rvalid && rv_err_q;
    p1_err    = p1_rvalid && rv_err_q;
    rdata     = mem_dout;
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Bench for dm_port_arbiter: directed stimulus, a per-cycle reference model
// with its own memory image, plus hand-computed literal expectations.
module tb_dm_port_arbiter;

  localparam int AW  = 12;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          p0_req, p0_we, p1_req, p1_we;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [31:0]   p0_wdata, p1_wdata;
  logic [1:0]    p0_mode, p1_mode;
  logic          p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
  logic [31:0]   rdata, mem_din, mem_dout;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [1:0]    mem_mode;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dm_port_arbiter #(.STARVE_LIM(LIM), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_mode(p0_mode),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_mode(p1_mode),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_err(p1_err),
    .rdata(rdata),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_mode(mem_mode),
    .mem_dout(mem_dout)
  );

  function automatic logic [31:0] ld_val(input logic [31:0] w, input logic [1:0] lane,
                                         input logic [1:0] mode);
    case (mode)
      2'b01:   ld_val = {24'b0, w[int'(lane)*8 +: 8]};
      2'b10:   ld_val = {16'b0, w[int'(lane[1])*16 +: 16]};
      default: ld_val = w;
    endcase
  endfunction

  function automatic logic [31:0] st_val(input logic [31:0] w, input logic [31:0] d,
                                         input logic [1:0] lane, input logic [1:0] mode);
    logic [31:0] r;
    r = w;
    case (mode)
      2'b01:   r[int'(lane)*8 +: 8] = d[7:0];
      2'b10:   r[int'(lane[1])*16 +: 16] = d[15:0];
      default: r = d;
    endcase
    return r;
  endfunction

  // Data memory device: registered read, mode 11 with WE=0 clears the word.
  logic [31:0] dev_mem [0:1023];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) dev_mem[i] <= '0;
      mem_dout <= '0;
    end else if (mem_we) begin
      dev_mem[mem_addr[AW-1:2]] <= st_val(dev_mem[mem_addr[AW-1:2]], mem_din, mem_addr[1:0], mem_mode);
    end else begin
      mem_dout <= ld_val(dev_mem[mem_addr[AW-1:2]], mem_addr[1:0], mem_mode);
      if (mem_mode == 2'b11) dev_mem[mem_addr[AW-1:2]] <= '0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: evaluated each negedge from the inputs that the next posedge samples.
  logic [31:0] model_mem [0:1023];
  int          streak = 0;
  bit          pend_valid = 0, pend_sel = 0, pend_err = 0, pend_load = 0;
  logic [31:0] pend_data = '0;

  always @(negedge clk) begin
    bit            w1, g0, g1, ill, wwe, ewe;
    logic [1:0]    wmode, emode;
    logic [AW-1:0] eaddr;
    logic [31:0]   edin;
    w1    = p1_req && (!p0_req || streak == LIM);
    g0    = !rst && p0_req && !w1;
    g1    = !rst && w1;
    eaddr = w1 ? p1_addr : p0_addr;
    edin  = w1 ? p1_wdata : p0_wdata;
    wmode = w1 ? p1_mode : p0_mode;
    wwe   = w1 ? p1_we : p0_we;
    ill   = (wmode == 2'b11);
    ewe   = (g0 || g1) && wwe && !ill;
    emode = ((g0 || g1) && !ill) ? wmode : 2'b00;

    chk("p0_gnt", 32'(p0_gnt), 32'(g0));
    chk("p1_gnt", 32'(p1_gnt), 32'(g1));
    chk("mem_we", 32'(mem_we), 32'(ewe));
    chk("mem_mode", 32'(mem_mode), 32'(emode));
    if (!rst) begin
      chk("mem_addr", 32'(mem_addr), 32'(eaddr));
      chk("mem_din", mem_din, edin);
    end
    chk("p0_rvalid", 32'(p0_rvalid), 32'(pend_valid && !pend_sel && !rst));
    chk("p1_rvalid", 32'(p1_rvalid), 32'(pend_valid && pend_sel && !rst));
    chk("p0_err", 32'(p0_err), 32'(pend_valid && !pend_sel && !rst && pend_err));
    chk("p1_err", 32'(p1_err), 32'(pend_valid && pend_sel && !rst && pend_err));
    if (pend_valid && !pend_err && pend_load && !rst) chk("rdata", rdata, pend_data);

    if (rst || !p1_req || g1) streak = 0;
    else if (streak < LIM) streak = streak + 1;
    pend_valid = g0 || g1;
    pend_sel   = g1;
    pend_err   = (g0 || g1) && ill;
    pend_load  = !wwe;
    pend_data  = ld_val(model_mem[eaddr[AW-1:2]], eaddr[1:0], wmode);
    if (rst) begin
      for (int i = 0; i < 1024; i++) model_mem[i] = '0;
    end else if (ewe) begin
      model_mem[eaddr[AW-1:2]] = st_val(model_mem[eaddr[AW-1:2]], edin, eaddr[1:0], wmode);
    end
  end

  task automatic drv(input bit r0, input bit w0, input logic [AW-1:0] a0, input logic [31:0] d0,
                     input logic [1:0] m0, input bit r1, input bit w1, input logic [AW-1:0] a1,
                     input logic [31:0] d1, input logic [1:0] m1);
    p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0; p0_mode = m0;
    p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1; p1_mode = m1;
  endtask

  task automatic idle;
    drv(0, 0, 12'h000, 32'h0, 2'b00, 0, 0, 12'h000, 32'h0, 2'b00);
  endtask

  task automatic both_load;
    drv(1, 0, 12'h010, 32'h0, 2'b00, 1, 0, 12'h000, 32'h0, 2'b00);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    both_load();
    for (int i = 0; i < 2; i++) begin
      #2;
      chk("rst_p0_gnt", 32'(p0_gnt), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      tick();
    end
    rst = 1'b0;
    #2; chk("first_p0_gnt", 32'(p0_gnt), 32'd1);
    tick();
    #2; chk("first_p0_rvalid", 32'(p0_rvalid), 32'd1);
    idle();
    tick();

    // Word store then load on port 0
    drv(1, 1, 12'h010, 32'hDEADBEEF, 2'b00, 0, 0, 12'h000, 32'h0, 2'b00);
    #2; chk("st_mem_we", 32'(mem_we), 32'd1); chk("st_mem_mode", 32'(mem_mode), 32'd0);
    tick();
    drv(1, 0, 12'h010, 32'h0, 2'b00, 0, 0, 12'h000, 32'h0, 2'b00);
    #2; chk("st_rvalid", 32'(p0_rvalid), 32'd1);
    tick();
    idle();
    #2; chk("ld_rvalid", 32'(p0_rvalid), 32'd1); chk("ld_rdata", rdata, 32'hDEADBEEF);
    tick();

    // Starvation: P1 every fifth cycle
    for (int i = 0; i < 15; i++) begin
      both_load();
      #2; chk("starve_p1_gnt", 32'(p1_gnt), 32'((i % 5) == 4));
      tick();
    end
    idle();
    tick();

    // Illegal mode on port 1 must not disturb the stored word
    drv(1, 1, 12'h030, 32'h12345678, 2'b00, 0, 0, 12'h000, 32'h0, 2'b00);
    tick();
    drv(0, 0, 12'h000, 32'h0, 2'b00, 1, 0, 12'h030, 32'h0, 2'b11);
    #2;
    chk("ill_p1_gnt", 32'(p1_gnt), 32'd1);
    chk("ill_mem_we", 32'(mem_we), 32'd0);
    chk("ill_mem_mode", 32'(mem_mode), 32'd0);
    tick();
    drv(1, 0, 12'h030, 32'h0, 2'b00, 0, 0, 12'h000, 32'h0, 2'b00);
    #2; chk("ill_p1_rvalid", 32'(p1_rvalid), 32'd1); chk("ill_p1_err", 32'(p1_err), 32'd1);
    tick();
    idle();
    #2; chk("ill_after_rdata", rdata, 32'h12345678);
    tick();

    // Interleaved responses
    drv(1, 1, 12'h020, 32'hA1B2C3D4, 2'b00, 0, 0, 12'h000, 32'h0, 2'b00);
    tick();
    drv(1, 1, 12'h024, 32'hCAFEF00D, 2'b00, 0, 0, 12'h000, 32'h0, 2'b00);
    tick();
    drv(1, 0, 12'h020, 32'h0, 2'b00, 0, 0, 12'h000, 32'h0, 2'b00);
    tick();
    drv(0, 0, 12'h000, 32'h0, 2'b00, 1, 0, 12'h024, 32'h0, 2'b01);
    #2;
    chk("il_p0_rvalid", 32'(p0_rvalid), 32'd1);
    chk("il_p1_rvalid_n1", 32'(p1_rvalid), 32'd0);
    chk("il_rdata0", rdata, 32'hA1B2C3D4);
    tick();
    idle();
    #2;
    chk("il_p1_rvalid", 32'(p1_rvalid), 32'd1);
    chk("il_p0_rvalid_n2", 32'(p0_rvalid), 32'd0);
    chk("il_rdata1", rdata, 32'h0000000D);
    tick();

    // Reset clears a partly built starvation count
    for (int i = 0; i < 3; i++) begin both_load(); tick(); end
    rst = 1'b1;
    #2; chk("rst2_p1_gnt", 32'(p1_gnt), 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      both_load();
      #2; chk("post_rst_p1_gnt", 32'(p1_gnt), 32'(i == 4));
      tick();
    end
    idle();
    tick();

    // Reset in the response cycle suppresses the p1 response
    drv(0, 0, 12'h000, 32'h0, 2'b00, 1, 0, 12'h020, 32'h0, 2'b00);
    #2; chk("mid_p1_gnt", 32'(p1_gnt), 32'd1);
    tick();
    idle();
    rst = 1'b1;
    #2; chk("mid_p1_rvalid", 32'(p1_rvalid), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
